// File: rtl/uplus_ten_gig_link_ctrl.sv
// ---------------------------------------------------------------------------
// uplus_ten_gig_link_ctrl
//
// Purpose:
//   Brings up a group of GT channels that share one QPLL. The sequence is:
//   reset the QPLL, wait for it to lock, release the enabled channels, and
//   wait for every enabled channel to report a debounced link-up. Lock
//   timeouts restart the QPLL. Link timeouts re-reset only the channels
//   that failed. Loss of lock at any point after lock restarts everything.
//
// Optional feature:
//   UPLUS_LINK_RETRY_CNT_EN - when defined, o_retry_cnt counts recovery
//   events and saturates at 255. When undefined, o_retry_cnt is tied to 0.
//
// Ports:
//   i_dclk            single clock for all logic
//   i_rst_n           asynchronous active-low reset
//   i_restart         synchronous pulse that restarts the whole bring-up
//   i_ch_enable       per-channel enable (synchronous)
//   i_qpll_lock       QPLL lock (asynchronous, synchronized internally)
//   i_stat_rx_status  per-channel rx status (asynchronous, synchronized)
//   o_qpll_reset      QPLL reset, active high
//   o_ch_reset        per-channel reset, active high
//   o_link_up         debounced per-channel link status
//   o_all_link_up     all enabled links up while in RUN (registered)
//   o_state           FSM state code (0 QPLL_RST .. 4 RUN)
//   o_lock_err        sticky lock-timeout flag
//   o_retry_cnt       saturating retry counter
// ---------------------------------------------------------------------------
module uplus_ten_gig_link_ctrl #(
    parameter int P_CHANNEL_NUM     = 2,
    parameter int P_QPLL_RST_CYCLES = 16,
    parameter int P_LOCK_TIMEOUT    = 100000,
    parameter int P_LINK_TIMEOUT    = 1000000,
    parameter int P_CH_RST_CYCLES   = 16,
    parameter int P_DEBOUNCE        = 8
) (
    input  logic                     i_dclk,
    input  logic                     i_rst_n,
    input  logic                     i_restart,
    input  logic [P_CHANNEL_NUM-1:0] i_ch_enable,
    input  logic                     i_qpll_lock,
    input  logic [P_CHANNEL_NUM-1:0] i_stat_rx_status,
    output logic                     o_qpll_reset,
    output logic [P_CHANNEL_NUM-1:0] o_ch_reset,
    output logic [P_CHANNEL_NUM-1:0] o_link_up,
    output logic                     o_all_link_up,
    output logic [2:0]               o_state,
    output logic                     o_lock_err,
    output logic [7:0]               o_retry_cnt
);

    typedef enum logic [2:0] {
        ST_QPLL_RST  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_WAIT_LINK = 3'd2,
        ST_CH_RST    = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam int TMAX_A = (P_QPLL_RST_CYCLES > P_LOCK_TIMEOUT)  ? P_QPLL_RST_CYCLES : P_LOCK_TIMEOUT;
    localparam int TMAX_B = (P_LINK_TIMEOUT    > P_CH_RST_CYCLES) ? P_LINK_TIMEOUT    : P_CH_RST_CYCLES;
    localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TW     = $clog2(TMAX) + 1;
    localparam int DW     = $clog2(P_DEBOUNCE + 1);

    // The timer holds the number of completed cycles in the current state,
    // so a limit of L is reached when the timer shows L-1.
    localparam logic [TW-1:0] T_QPLL_END = TW'(P_QPLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK_END = TW'(P_LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_LINK_END = TW'(P_LINK_TIMEOUT - 1);
    localparam logic [TW-1:0] T_CHR_END  = TW'(P_CH_RST_CYCLES - 1);
    localparam logic [DW-1:0] DEB_FULL   = DW'(P_DEBOUNCE);
    localparam logic [DW-1:0] DEB_LAST   = DW'(P_DEBOUNCE - 1);

    // ---------------- synchronizers ----------------
    logic                     lock_s1_q, lock_s2_q;
    logic [P_CHANNEL_NUM-1:0] rx_s1_q, rx_s2_q;

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lock_s1_q <= 1'b0;
            lock_s2_q <= 1'b0;
            rx_s1_q   <= '0;
            rx_s2_q   <= '0;
        end else begin
            lock_s1_q <= i_qpll_lock;
            lock_s2_q <= lock_s1_q;
            rx_s1_q   <= i_stat_rx_status;
            rx_s2_q   <= rx_s1_q;
        end
    end

    // ---------------- FSM registers and outputs ----------------
    state_t                   state_q, state_d;
    logic [TW-1:0]            timer_q;
    logic [P_CHANNEL_NUM-1:0] mask_q, mask_d;
    logic                     qpll_reset_q;
    logic [P_CHANNEL_NUM-1:0] ch_reset_q, ch_reset_d;
    logic                     all_link_up_q;
    logic                     lock_err_q;
    logic                     lock_to;
    logic                     all_en_up;

    // ---------------- debounce ----------------
    logic [P_CHANNEL_NUM-1:0][DW-1:0] deb_cnt_q;
    logic [P_CHANNEL_NUM-1:0]         link_up_q;

    // A sample counts only while the channel is enabled and out of reset;
    // any other sample restarts the count and drops link-up.
    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            deb_cnt_q <= '0;
            link_up_q <= '0;
        end else begin
            for (int n = 0; n < P_CHANNEL_NUM; n++) begin
                if (i_ch_enable[n] && !ch_reset_q[n] && rx_s2_q[n]) begin
                    if (deb_cnt_q[n] != DEB_FULL) deb_cnt_q[n] <= deb_cnt_q[n] + DW'(1);
                    link_up_q[n] <= (deb_cnt_q[n] >= DEB_LAST);
                end else begin
                    deb_cnt_q[n] <= '0;
                    link_up_q[n] <= 1'b0;
                end
            end
        end
    end

    // Disabled channels count as up, so an empty mask is vacuously all-up.
    assign all_en_up = &(link_up_q | ~i_ch_enable);

    always_comb begin
        state_d = state_q;
        lock_to = 1'b0;
        case (state_q)
            ST_QPLL_RST: begin
                if (timer_q == T_QPLL_END) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s2_q) begin
                    state_d = ST_WAIT_LINK;
                end else if (timer_q == T_LOCK_END) begin
                    state_d = ST_QPLL_RST;
                    lock_to = 1'b1;
                end
            end
            ST_WAIT_LINK: begin
                if (!lock_s2_q)                  state_d = ST_QPLL_RST;
                else if (all_en_up)              state_d = ST_RUN;
                else if (timer_q == T_LINK_END)  state_d = ST_CH_RST;
            end
            ST_CH_RST: begin
                if (!lock_s2_q)                  state_d = ST_QPLL_RST;
                else if (timer_q == T_CHR_END)   state_d = ST_WAIT_LINK;
            end
            ST_RUN: begin
                if (!lock_s2_q)                  state_d = ST_QPLL_RST;
                else if (!all_en_up)             state_d = ST_WAIT_LINK;
            end
            default: state_d = ST_QPLL_RST;
        endcase
        // Restart wins over everything, including a same-cycle lock timeout.
        if (i_restart) begin
            state_d = ST_QPLL_RST;
            lock_to = 1'b0;
        end
    end

    // Only the channels that failed during the link wait are re-reset.
    always_comb begin
        mask_d = mask_q;
        if (state_q == ST_WAIT_LINK && state_d == ST_CH_RST) mask_d = i_ch_enable & ~link_up_q;
    end

    // Channels are held in reset until the QPLL has locked.
    always_comb begin
        case (state_d)
            ST_QPLL_RST, ST_WAIT_LOCK: ch_reset_d = '1;
            ST_CH_RST:                 ch_reset_d = mask_d | ~i_ch_enable;
            default:                   ch_reset_d = ~i_ch_enable;
        endcase
    end

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_QPLL_RST;
            timer_q       <= '0;
            mask_q        <= '0;
            qpll_reset_q  <= 1'b1;
            ch_reset_q    <= '1;
            all_link_up_q <= 1'b0;
            lock_err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // A restart re-enters QPLL_RST, so it clears the timer as well.
            if (state_d != state_q || i_restart) timer_q <= '0;
            else if (timer_q != '1)              timer_q <= timer_q + TW'(1);
            mask_q        <= mask_d;
            qpll_reset_q  <= (state_d == ST_QPLL_RST);
            ch_reset_q    <= ch_reset_d;
            all_link_up_q <= (state_q == ST_RUN) && (i_ch_enable != '0) && all_en_up;
            if (lock_to) lock_err_q <= 1'b1;
        end
    end

`ifdef UPLUS_LINK_RETRY_CNT_EN
    logic [7:0] retry_cnt_q;
    logic       retry_evt;

    // Every non-restart entry into QPLL_RST is a timeout or lock loss.
    assign retry_evt = !i_restart && (state_d != state_q) &&
                       (state_d == ST_QPLL_RST || state_d == ST_CH_RST);

    always_ff @(posedge i_dclk or negedge i_rst_n) begin
        if (!i_rst_n)                            retry_cnt_q <= 8'd0;
        else if (retry_evt && retry_cnt_q != 8'hFF) retry_cnt_q <= retry_cnt_q + 8'd1;
    end
    assign o_retry_cnt = retry_cnt_q;
`else
    assign o_retry_cnt = 8'd0;
`endif

    assign o_qpll_reset  = qpll_reset_q;
    assign o_ch_reset    = ch_reset_q;
    assign o_link_up     = link_up_q;
    assign o_all_link_up = all_link_up_q;
    assign o_state       = state_q;
    assign o_lock_err    = lock_err_q;

endmodule

// File: tb/tb_uplus_ten_gig_link_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for uplus_ten_gig_link_ctrl: directed bring-up scenarios followed by
// a random phase. A cycle model built from the bring-up rules (cycles spent
// in each phase, consecutive-sample counts) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_uplus_ten_gig_link_ctrl;

    localparam int N  = 2;
    localparam int QR = 16;
    localparam int LT = 100;
    localparam int KT = 200;
    localparam int CR = 16;
    localparam int DB = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         restart = 1'b0;
    logic [N-1:0] en = '0;
    logic         lock = 1'b0;
    logic [N-1:0] rx = '0;

    logic         o_qpll_reset;
    logic [N-1:0] o_ch_reset;
    logic [N-1:0] o_link_up;
    logic         o_all_link_up;
    logic [2:0]   o_state;
    logic         o_lock_err;
    logic [7:0]   o_retry_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uplus_ten_gig_link_ctrl #(
        .P_CHANNEL_NUM    (N),
        .P_QPLL_RST_CYCLES(QR),
        .P_LOCK_TIMEOUT   (LT),
        .P_LINK_TIMEOUT   (KT),
        .P_CH_RST_CYCLES  (CR),
        .P_DEBOUNCE       (DB)
    ) dut (
        .i_dclk          (clk),
        .i_rst_n         (rst_n),
        .i_restart       (restart),
        .i_ch_enable     (en),
        .i_qpll_lock     (lock),
        .i_stat_rx_status(rx),
        .o_qpll_reset    (o_qpll_reset),
        .o_ch_reset      (o_ch_reset),
        .o_link_up       (o_link_up),
        .o_all_link_up   (o_all_link_up),
        .o_state         (o_state),
        .o_lock_err      (o_lock_err),
        .o_retry_cnt     (o_retry_cnt)
    );

    // ---------------- reference model ----------------
    // phase: 0 QPLL reset, 1 wait lock, 2 wait link, 3 channel reset, 4 run
    int           m_phase;
    int           m_spent;          // cycles completed in the current phase
    logic [1:0]   m_lock_hist;      // [1] = oldest, the value the logic sees
    logic [N-1:0] m_rx_old, m_rx_new;
    int           m_run_len[N];     // consecutive usable high samples
    logic [N-1:0] m_up, m_chrst, m_failed;
    logic         m_qrst, m_all, m_err;
    int           m_retry;

    task automatic model_reset();
        m_phase = 0; m_spent = 0; m_lock_hist = 2'b00;
        m_rx_old = '0; m_rx_new = '0;
        for (int n = 0; n < N; n++) m_run_len[n] = 0;
        m_up = '0; m_chrst = '1; m_failed = '0;
        m_qrst = 1'b1; m_all = 1'b0; m_err = 1'b0; m_retry = 0;
    endtask

    task automatic model_step();
        logic         locked;
        logic [N-1:0] seen, up_before;
        logic         every_up, lock_timeout;
        int           next, spent_now;
        locked    = m_lock_hist[1];
        seen      = m_rx_old;
        up_before = m_up;
        m_lock_hist = {m_lock_hist[0], lock};
        m_rx_old = m_rx_new;
        m_rx_new = rx;
        every_up = ((up_before & en) == en);
        m_all = (m_phase == 4) && (en != 0) && every_up;
        for (int n = 0; n < N; n++) begin
            if (en[n] && !m_chrst[n] && seen[n]) begin
                m_run_len[n] = (m_run_len[n] < DB) ? m_run_len[n] + 1 : DB;
                m_up[n] = (m_run_len[n] >= DB);
            end else begin
                m_run_len[n] = 0;
                m_up[n] = 1'b0;
            end
        end
        spent_now = m_spent + 1;
        next = m_phase;
        lock_timeout = 1'b0;
        if (m_phase == 0) begin
            if (spent_now >= QR) next = 1;
        end else if (m_phase == 1) begin
            if (locked) next = 2;
            else if (spent_now >= LT) begin next = 0; lock_timeout = 1'b1; end
        end else begin
            if (!locked)                                 next = 0;
            else if (m_phase == 2 && every_up)           next = 4;
            else if (m_phase == 2 && spent_now >= KT)    next = 3;
            else if (m_phase == 3 && spent_now >= CR)    next = 2;
            else if (m_phase == 4 && !every_up)          next = 2;
        end
        if (restart) begin
            next = 0;
            lock_timeout = 1'b0;
        end else if (next != m_phase && (next == 0 || next == 3)) begin
`ifdef UPLUS_LINK_RETRY_CNT_EN
            if (m_retry < 255) m_retry = m_retry + 1;
`endif
        end
        if (m_phase == 2 && next == 3) m_failed = en & ~up_before;
        if (lock_timeout) m_err = 1'b1;
        m_spent = (next != m_phase || restart) ? 0 : spent_now;
        m_phase = next;
        m_qrst = (next == 0);
        if (next <= 1)      m_chrst = '1;
        else if (next == 3) m_chrst = m_failed | ~en;
        else                m_chrst = ~en;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("state",       32'(o_state),       32'(m_phase));
        chk("qpll_reset",  32'(o_qpll_reset),  32'(m_qrst));
        chk("ch_reset",    32'(o_ch_reset),    32'(m_chrst));
        chk("link_up",     32'(o_link_up),     32'(m_up));
        chk("all_link_up", 32'(o_all_link_up), 32'(m_all));
        chk("lock_err",    32'(o_lock_err),    32'(m_err));
        chk("retry_cnt",   32'(o_retry_cnt),   32'(m_retry));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"},    32'(o_state),       32'd0);
        chk({tag, "_qpll"},     32'(o_qpll_reset),  32'd1);
        chk({tag, "_chrst"},    32'(o_ch_reset),    32'd3);
        chk({tag, "_linkup"},   32'(o_link_up),     32'd0);
        chk({tag, "_all"},      32'(o_all_link_up), 32'd0);
        chk({tag, "_lockerr"},  32'(o_lock_err),    32'd0);
        chk({tag, "_retry"},    32'(o_retry_cnt),   32'd0);
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n = 0;
        while (o_state !== 3'(st) && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 32'(o_state), 32'(st));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        en = 2'b11;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;

        // Normal bring-up: lock at cycle 40, both statuses at cycle 60.
        step(15);
        chk("qpll_rst_held", 32'(o_qpll_reset), 32'd1);
        step(1);
        chk("qpll_rst_released", 32'(o_qpll_reset), 32'd0);
        chk("wait_lock_state", 32'(o_state), 32'd1);
        step(24);
        lock = 1'b1;
        step(20);
        rx = 2'b11;
        step(15);
        chk("run_state", 32'(o_state), 32'd4);
        chk("run_link_up", 32'(o_link_up), 32'd3);
        chk("run_all_up", 32'(o_all_link_up), 32'd1);

        // One-cycle glitch on ch0 while running: back to link wait, no reset.
        rx = 2'b10;
        step(1);
        rx = 2'b11;
        step(5);
        chk("glitch_state", 32'(o_state), 32'd2);
        chk("glitch_link_up", 32'(o_link_up), 32'd2);
        chk("glitch_no_reset", 32'(o_ch_reset), 32'd0);
        step(8);
        chk("glitch_recovered", 32'(o_state), 32'd4);

        // Lock and links drop together: lock loss wins.
        lock = 1'b0;
        rx = 2'b00;
        step(4);
        chk("lockdrop_state", 32'(o_state), 32'd0);
        chk("lockdrop_chrst", 32'(o_ch_reset), 32'd3);

        // Ch1 stuck low: only ch1 is re-reset after the link timeout.
        lock = 1'b1;
        rx = 2'b01;
        wait_state(3, 400, "ch_rst_entered");
        chk("ch_rst_mask", 32'(o_ch_reset), 32'd2);
        chk("ch_rst_ch0_up", 32'(o_link_up[0]), 32'd1);
        step(15);
        chk("ch_rst_held", 32'(o_ch_reset), 32'd2);
        step(1);
        chk("ch_rst_done_state", 32'(o_state), 32'd2);
        chk("ch_rst_done_chrst", 32'(o_ch_reset), 32'd0);

        // Lock never returns: lock timeout sets the sticky error.
        lock = 1'b0;
        begin
            int n = 0;
            while (o_lock_err !== 1'b1 && n < 400) begin step(1); n++; end
        end
        chk("lock_err_set", 32'(o_lock_err), 32'd1);
        chk("lock_to_state", 32'(o_state), 32'd0);
`ifdef UPLUS_LINK_RETRY_CNT_EN
        chk("retry_after_to", 32'(o_retry_cnt), 32'd4);
`else
        chk("retry_after_to", 32'(o_retry_cnt), 32'd0);
`endif

        // Restart from link wait keeps the sticky error.
        lock = 1'b1;
        rx = 2'b00;
        wait_state(2, 200, "pre_restart_state");
        step(5);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        chk("restart_state", 32'(o_state), 32'd0);
        chk("restart_keeps_err", 32'(o_lock_err), 32'd1);

        // Random phase.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) en = N'($urandom_range(0, 3));
            for (int n = 0; n < N; n++)
                if ($urandom_range(0, 29) == 0) rx[n] = ~rx[n];
            if (lock && $urandom_range(0, 499) == 0)       lock = 1'b0;
            else if (!lock && $urandom_range(0, 19) == 0)  lock = 1'b1;
            restart = ($urandom_range(0, 399) == 0);
            step(1);
        end
        restart = 1'b0;

        // Asynchronous reset in the middle of link wait.
        lock = 1'b1;
        en = 2'b11;
        rx = 2'b00;
        wait_state(2, 400, "pre_reset_state");
        step(3);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        rx = 2'b11;
        step(60);
        chk("post_reset_run", 32'(o_state), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uplus_ten_gig_link_ctrl.md
UPLUS_TEN_GIG_LINK_CTRL -- requirements
Module: uplus_ten_gig_link_ctrl

Interface
REQ-001 SHALL have parameter P_CHANNEL_NUM, default 2, number of GT channels sharing one QPLL (1..4).
REQ-002 SHALL have parameter P_QPLL_RST_CYCLES, default 16, QPLL reset pulse length in i_dclk cycles.
REQ-003 SHALL have parameter P_LOCK_TIMEOUT, default 100000, maximum i_dclk cycles to wait for QPLL lock.
REQ-004 SHALL have parameter P_LINK_TIMEOUT, default 1000000, maximum cycles to wait for all enabled links up.
REQ-005 SHALL have parameter P_CH_RST_CYCLES, default 16, channel reset pulse length.
REQ-006 SHALL have parameter P_DEBOUNCE, default 8, consecutive high samples required for link-up.
REQ-007 SHALL have i_dclk  input  1  single clock for all logic.
REQ-008 SHALL have i_rst_n  input  1  asynchronous active-low reset.
REQ-009 SHALL have i_restart  input  1  synchronous pulse that restarts the full bring-up.
REQ-010 SHALL have i_ch_enable  input  P_CHANNEL_NUM  per-channel enable, synchronous to i_dclk.
REQ-011 SHALL have i_qpll_lock  input  1  QPLL lock, asynchronous.
REQ-012 SHALL have i_stat_rx_status  input  P_CHANNEL_NUM  per-channel rx status, asynchronous.
REQ-013 SHALL have o_qpll_reset  output  1  QPLL reset, active high.
REQ-014 SHALL have o_ch_reset  output  P_CHANNEL_NUM  per-channel reset, active high.
REQ-015 SHALL have o_link_up  output  P_CHANNEL_NUM  debounced per-channel link status.
REQ-016 SHALL have o_all_link_up  output  1  all enabled links up and state RUN.
REQ-017 SHALL have o_state  output  3  FSM state code.
REQ-018 SHALL have o_lock_err  output  1  sticky flag, set on any lock timeout.
REQ-019 SHALL have o_retry_cnt  output  8  saturating retry counter.

Function
REQ-020 SHALL pass i_qpll_lock and each i_stat_rx_status bit through two-flop synchronizers before use.
REQ-021 SHALL set o_link_up[n] after P_DEBOUNCE consecutive synchronized-high samples with channel n enabled and o_ch_reset[n] low, and SHALL clear it on the first low sample or when channel n is disabled.
REQ-022 SHALL implement states QPLL_RST=0, WAIT_LOCK=1, WAIT_LINK=2, CH_RST=3, RUN=4, with one shared timer that clears on every state entry.
REQ-023 QPLL_RST: o_qpll_reset=1 and o_ch_reset all ones; after P_QPLL_RST_CYCLES the FSM SHALL go to WAIT_LOCK.
REQ-024 WAIT_LOCK: o_qpll_reset=0; synchronized lock SHALL cause a transition to WAIT_LINK; reaching P_LOCK_TIMEOUT SHALL set o_lock_err and return to QPLL_RST.
REQ-025 WAIT_LINK: o_ch_reset[n]=~i_ch_enable[n]; all enabled o_link_up high (vacuously true when the enable mask is zero) SHALL cause a transition to RUN; reaching P_LINK_TIMEOUT SHALL latch mask = enabled & ~o_link_up and go to CH_RST.
REQ-026 CH_RST: o_ch_reset = latched mask | ~i_ch_enable for P_CH_RST_CYCLES, then the FSM SHALL go to WAIT_LINK.
REQ-027 RUN: any enabled channel with o_link_up low SHALL cause a transition to WAIT_LINK without a reset.
REQ-028 In WAIT_LINK, CH_RST or RUN, loss of synchronized lock SHALL cause a transition to QPLL_RST; it takes priority over a same-cycle timeout or link drop.
REQ-029 i_restart SHALL force QPLL_RST from any state next cycle, SHALL override all other transitions and SHALL NOT clear o_lock_err.
REQ-030 Disabled channels SHALL hold o_ch_reset high in every state.
REQ-031 o_all_link_up SHALL be registered: (state==RUN) & (enable mask != 0) & all enabled o_link_up high.
REQ-032 Timer width SHALL be $clog2 of the largest timeout parameter plus 1, with no wrap-around inside any state.

Reset
REQ-033 While i_rst_n is low: state QPLL_RST, timer 0, o_qpll_reset=1, o_ch_reset all ones, o_link_up=0, o_all_link_up=0, o_lock_err=0, o_retry_cnt=0, synchronizers and debounce counters 0.
REQ-034 Deassertion of i_rst_n SHALL start a full QPLL_RST sequence.

Configuration
REQ-035 With macro UPLUS_LINK_RETRY_CNT_EN defined: o_retry_cnt SHALL increment on each entry to QPLL_RST caused by timeout or lock loss and on each entry to CH_RST, saturating at 255, cleared only by i_rst_n.
REQ-036 Without UPLUS_LINK_RETRY_CNT_EN: o_retry_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification (P_CHANNEL_NUM=2, QPLL_RST=16, LOCK_TO=100, LINK_TO=200, CH_RST=16, DEBOUNCE=8)
REQ-037 Lock at cycle 40, both statuses high at 60, enable=2'b11 -> o_qpll_reset low after 16 cycles; o_link_up=2'b11 after 2+8 cycles; state 4; o_all_link_up=1.
REQ-038 Lock never asserts -> o_lock_err=1 at 100 cycles in WAIT_LOCK; QPLL_RST re-entered; o_retry_cnt=1 (macro on) or 0 (macro off).
REQ-039 Ch1 status stuck low -> after 200 cycles in WAIT_LINK, o_ch_reset=2'b10 for 16 cycles, ch0 unaffected, state returns to 2.
REQ-040 In RUN, ch0 status low for one cycle -> o_link_up[0]=0 after sync delay, state 2, no reset pulse; state 4 again after 8 high cycles.
REQ-041 In RUN, lock drops in the same cycle as a link drop -> state 0, o_ch_reset=2'b11.
REQ-042 i_rst_n asserted mid-WAIT_LINK -> all outputs take reset values immediately (asynchronous); o_lock_err cleared.
